// File: rtl/pong_hv_sequencer_pkg.sv
// Default video timing shared by the sequencer, video and game logic,
// plus a line-phase decode helper for debug views.
package pong_timing_pkg;

    localparam int DEF_H_W        = 9;
    localparam int DEF_V_W        = 9;
    localparam int DEF_H_TOTAL    = 455;
    localparam int DEF_V_TOTAL    = 262;
    localparam int DEF_HBLANK_END = 80;
    localparam int DEF_HSYNC_BEG  = 32;
    localparam int DEF_HSYNC_END  = 64;
    localparam int DEF_VBLANK_END = 16;
    localparam int DEF_VSYNC_BEG  = 4;
    localparam int DEF_VSYNC_END  = 8;

    typedef enum logic [1:0] {BLANK_PRE, SYNC, BLANK_POST, ACTIVE} line_phase_e;

    // Phase of a line (or frame) given its count; order BLANK_PRE, SYNC, BLANK_POST, ACTIVE.
    function automatic line_phase_e phase_of(int c, int sync_beg, int sync_end, int blank_end);
        if (c < sync_beg)       return BLANK_PRE;
        else if (c < sync_end)  return SYNC;
        else if (c < blank_end) return BLANK_POST;
        return ACTIVE;
    endfunction

endpackage

// File: rtl/pong_hv_sequencer_if.sv
// Enable/hold inputs and H/V timing outputs of the sequencer.
interface pong_hv_sequencer_if #(
    parameter int H_W = pong_timing_pkg::DEF_H_W,
    parameter int V_W = pong_timing_pkg::DEF_V_W
);
    logic           clk_en;
    logic           hold;
    logic [H_W-1:0] hcnt;
    logic [V_W-1:0] vcnt;
    logic           hreset;
    logic           vreset;
    logic           hblank;
    logic           vblank;
    logic           _hsync;
    logic           _vsync;
    logic           frame_tick;

    modport master (input clk_en, hold,
                    output hcnt, vcnt, hreset, vreset, hblank, vblank, _hsync, _vsync, frame_tick);
    modport slave  (output clk_en, hold,
                    input hcnt, vcnt, hreset, vreset, hblank, vblank, _hsync, _vsync, frame_tick);
endinterface

// File: rtl/pong_hv_sequencer_modn.sv
// Mod-N synchronous counter with terminal-count flag; stands in for one
// ripple chain plus its master-reset decode.
module sync_modn_counter #(
    parameter int W = 9,
    parameter int N = 455
) (
    input  logic         clk,
    input  logic         _reset,
    input  logic         en,
    output logic [W-1:0] cnt,
    output logic         tc
);
    assign tc = (int'(cnt) == N - 1);

    always_ff @(posedge clk) begin
        if (!_reset)  cnt <= '0;
        else if (en)  cnt <= tc ? '0 : cnt + 1'b1;
    end
endmodule

// File: rtl/pong_hv_sequencer.sv
// H/V count sequencer: clock-enabled counters, registered blank/sync/reset
// decodes aligned with the visible counts, and a one-clock frame tick.
module pong_hv_sequencer
    import pong_timing_pkg::*;
#(
    parameter int H_W        = DEF_H_W,
    parameter int V_W        = DEF_V_W,
    parameter int H_TOTAL    = DEF_H_TOTAL,
    parameter int V_TOTAL    = DEF_V_TOTAL,
    parameter int HBLANK_END = DEF_HBLANK_END,
    parameter int HSYNC_BEG  = DEF_HSYNC_BEG,
    parameter int HSYNC_END  = DEF_HSYNC_END,
    parameter int VBLANK_END = DEF_VBLANK_END,
    parameter int VSYNC_BEG  = DEF_VSYNC_BEG,
    parameter int VSYNC_END  = DEF_VSYNC_END
) (
    input  logic                clk,
    input  logic                _reset,
    pong_hv_sequencer_if.master bus
);
    if (H_TOTAL > 2**H_W || V_TOTAL > 2**V_W) begin : g_bad_total
        $error("pong_hv_sequencer: TOTAL does not fit counter width");
    end
    if (HSYNC_BEG >= HSYNC_END || VSYNC_BEG >= VSYNC_END) begin : g_bad_sync
        $error("pong_hv_sequencer: sync window empty or reversed");
    end
    if (HBLANK_END > H_TOTAL || HSYNC_END > H_TOTAL ||
        VBLANK_END > V_TOTAL || VSYNC_END > V_TOTAL) begin : g_bad_end
        $error("pong_hv_sequencer: window end beyond TOTAL");
    end

    logic           h_en, v_en, h_tc, v_tc;
    logic [H_W-1:0] hcnt, hnext;
    logic [V_W-1:0] vcnt, vnext;
    logic           hreset, vreset, hblank, vblank, hsync_n, vsync_n, frame_tick;

    // hold wins over clk_en; V advances only on the H terminal count.
    assign h_en = bus.clk_en & ~bus.hold;
    assign v_en = h_en & h_tc;

    sync_modn_counter #(.W(H_W), .N(H_TOTAL)) u_hcnt (
        .clk(clk), ._reset(_reset), .en(h_en), .cnt(hcnt), .tc(h_tc)
    );
    sync_modn_counter #(.W(V_W), .N(V_TOTAL)) u_vcnt (
        .clk(clk), ._reset(_reset), .en(v_en), .cnt(vcnt), .tc(v_tc)
    );

    // Decodes are taken from the post-edge counts so they line up with hcnt/vcnt.
    always_comb begin
        hnext = hcnt;
        vnext = vcnt;
        if (h_en) hnext = h_tc ? '0 : hcnt + 1'b1;
        if (v_en) vnext = v_tc ? '0 : vcnt + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!_reset) begin
            hreset  <= 1'b0;
            vreset  <= 1'b0;
            hblank  <= 1'b1;
            vblank  <= 1'b1;
            hsync_n <= 1'b1;
            vsync_n <= 1'b1;
        end else if (h_en) begin
            hreset  <= (int'(hnext) == H_TOTAL - 1);
            vreset  <= (int'(vnext) == V_TOTAL - 1);
            hblank  <= (int'(hnext) < HBLANK_END);
            vblank  <= (int'(vnext) < VBLANK_END);
            hsync_n <= !(int'(hnext) >= HSYNC_BEG && int'(hnext) < HSYNC_END);
            vsync_n <= !(int'(vnext) >= VSYNC_BEG && int'(vnext) < VSYNC_END);
        end
    end

    always_ff @(posedge clk) begin
        if (!_reset) frame_tick <= 1'b0;
        else         frame_tick <= h_en & h_tc & v_tc;
    end

    assign bus.hcnt       = hcnt;
    assign bus.vcnt       = vcnt;
    assign bus.hreset     = hreset;
    assign bus.vreset     = vreset;
    assign bus.hblank     = hblank;
    assign bus.vblank     = vblank;
    assign bus._hsync     = hsync_n;
    assign bus._vsync     = vsync_n;
    assign bus.frame_tick = frame_tick;
endmodule

// File: tb/tb_pong_hv_sequencer.sv
// Bench: default-timing DUT (a) plus a shrunken-timing DUT (b) for full frames,
// both compared every cycle against a linear pixel-index model.
module tb_pong_hv_sequencer;
    import pong_timing_pkg::*;

    typedef struct {int ht, vt, hbe, hsb, hse, vbe, vsb, vse;} tim_t;
    typedef struct packed {
        logic [15:0] h, v;
        logic hr, vr, hb, vb, hs_n, vs_n, ft;
    } obs_t;
    typedef struct {bit rst_n, en, hold; int h, v; bit hb, hs_n, ft;} vec_t;

    tim_t ta = '{455, 262, 80, 32, 64, 16, 4, 8};
    tim_t tb = '{16, 12, 8, 3, 6, 4, 1, 3};

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    pong_hv_sequencer_if bus_a();
    pong_hv_sequencer_if #(.H_W(4), .V_W(4)) bus_b();

    pong_hv_sequencer dut_a (.clk(clk), ._reset(rst_n), .bus(bus_a));
    pong_hv_sequencer #(
        .H_W(4), .V_W(4), .H_TOTAL(16), .V_TOTAL(12),
        .HBLANK_END(8), .HSYNC_BEG(3), .HSYNC_END(6),
        .VBLANK_END(4), .VSYNC_BEG(1), .VSYNC_END(3)
    ) dut_b (.clk(clk), ._reset(rst_n), .bus(bus_b));

    always #5 clk = ~clk;

    int    n_cmp = 0;
    int    n_bad = 0;
    int    pix_a = 0, pix_b = 0;
    bit    ft_a = 0, ft_b = 0;
    string tag = "init";

    function automatic obs_t model_obs(tim_t t, int pix, bit ft);
        obs_t o;
        int h = pix % t.ht;
        int v = pix / t.ht;
        o.h    = 16'(h);
        o.v    = 16'(v);
        o.hr   = (h == t.ht - 1);
        o.vr   = (v == t.vt - 1);
        o.hb   = (h < t.hbe);
        o.vb   = (v < t.vbe);
        o.hs_n = !(h >= t.hsb && h < t.hse);
        o.vs_n = !(v >= t.vsb && v < t.vse);
        o.ft   = ft;
        return o;
    endfunction

    // The whole raster is one linear pixel index that wraps at ht*vt.
    function automatic void model_step(tim_t t, bit r, bit en, bit hold, inout int pix, inout bit ft);
        if (!r) begin
            pix = 0;
            ft  = 0;
        end else if (en && !hold) begin
            pix = (pix + 1) % (t.ht * t.vt);
            ft  = (pix == 0);
        end else begin
            ft = 0;
        end
    endfunction

    function automatic obs_t get_a();
        obs_t o;
        o.h = 16'(bus_a.hcnt); o.v = 16'(bus_a.vcnt);
        o.hr = bus_a.hreset; o.vr = bus_a.vreset; o.hb = bus_a.hblank; o.vb = bus_a.vblank;
        o.hs_n = bus_a._hsync; o.vs_n = bus_a._vsync; o.ft = bus_a.frame_tick;
        return o;
    endfunction

    function automatic obs_t get_b();
        obs_t o;
        o.h = 16'(bus_b.hcnt); o.v = 16'(bus_b.vcnt);
        o.hr = bus_b.hreset; o.vr = bus_b.vreset; o.hb = bus_b.hblank; o.vb = bus_b.vblank;
        o.hs_n = bus_b._hsync; o.vs_n = bus_b._vsync; o.ft = bus_b.frame_tick;
        return o;
    endfunction

    task automatic check(string name, obs_t act, obs_t exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got h=%0d v=%0d hr,vr,hb,vb,hs_n,vs_n,ft=%b want h=%0d v=%0d flags=%b",
                     name, act.h, act.v, {act.hr, act.vr, act.hb, act.vb, act.hs_n, act.vs_n, act.ft},
                     exp.h, exp.v, {exp.hr, exp.vr, exp.hb, exp.vb, exp.hs_n, exp.vs_n, exp.ft});
        end
    endtask

    task automatic check_int(string name, int act, int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    // Apply one clock of inputs to both DUTs, advance models, compare #1 after the edge.
    task automatic cyc(bit r, bit ea, bit ha, bit eb, bit hb);
        rst_n        = r;
        bus_a.clk_en = ea; bus_a.hold = ha;
        bus_b.clk_en = eb; bus_b.hold = hb;
        @(posedge clk);
        model_step(ta, r, ea, ha, pix_a, ft_a);
        model_step(tb, r, eb, hb, pix_b, ft_b);
        #1;
        check($sformatf("%s/a", tag), get_a(), model_obs(ta, pix_a, ft_a));
        check($sformatf("%s/b", tag), get_b(), model_obs(tb, pix_b, ft_b));
    endtask

    initial begin
        vec_t tbl[8];
        int   hs_low, hr_cnt, hb_fall, ft_cnt, guard, target;

        tbl[0] = '{0, 1, 0, 0, 0, 1, 1, 0};
        tbl[1] = '{0, 1, 0, 0, 0, 1, 1, 0};
        tbl[2] = '{0, 1, 0, 0, 0, 1, 1, 0};
        tbl[3] = '{1, 1, 0, 1, 0, 1, 1, 0};
        tbl[4] = '{1, 0, 0, 1, 0, 1, 1, 0};
        tbl[5] = '{1, 1, 1, 1, 0, 1, 1, 0};
        tbl[6] = '{1, 1, 0, 2, 0, 1, 1, 0};
        tbl[7] = '{1, 0, 1, 2, 0, 1, 1, 0};

        tag = "table";
        for (int i = 0; i < 8; i++) begin
            cyc(tbl[i].rst_n, tbl[i].en, tbl[i].hold, 1'b0, 1'b0);
            check_int($sformatf("tbl%0d.h", i), int'(bus_a.hcnt), tbl[i].h);
            check_int($sformatf("tbl%0d.v", i), int'(bus_a.vcnt), tbl[i].v);
            check_int($sformatf("tbl%0d.hb", i), int'(bus_a.hblank), int'(tbl[i].hb));
            check_int($sformatf("tbl%0d.hs", i), int'(bus_a._hsync), int'(tbl[i].hs_n));
            check_int($sformatf("tbl%0d.ft", i), int'(bus_a.frame_tick), int'(tbl[i].ft));
        end

        tag = "hwrap";
        cyc(0, 1, 0, 0, 0);
        hs_low = 0; hr_cnt = 0; hb_fall = -1;
        for (int i = 0; i < 455; i++) begin
            cyc(1, 1, 0, 0, 0);
            if (!bus_a._hsync) hs_low++;
            if (bus_a.hreset) begin
                hr_cnt++;
                check_int("hreset_at", int'(bus_a.hcnt), 454);
            end
            if (!bus_a.hblank && hb_fall < 0) hb_fall = int'(bus_a.hcnt);
        end
        check_int("hsync_low_clks", hs_low, 32);
        check_int("hreset_clks", hr_cnt, 1);
        check_int("hblank_fall_h", hb_fall, 80);
        check_int("hwrap_h", int'(bus_a.hcnt), 0);
        check_int("hwrap_v", int'(bus_a.vcnt), 1);

        tag = "hold";
        for (int i = 0; i < 200; i++) cyc(1, 1, 0, 0, 0);
        for (int i = 0; i < 10; i++) cyc(1, 1, 1, 0, 0);
        check_int("hold_h", int'(bus_a.hcnt), 200);
        cyc(1, 1, 0, 0, 0);
        check_int("resume_h", int'(bus_a.hcnt), 201);

        tag = "midrst";
        target = 100 * 455 + 300;
        guard  = 0;
        while (pix_a != target && guard < 50000) begin
            cyc(1, 1, 0, 0, 0);
            guard++;
        end
        check_int("reach_h", int'(bus_a.hcnt), 300);
        check_int("reach_v", int'(bus_a.vcnt), 100);
        cyc(0, 1, 0, 0, 0);
        check_int("midrst_h", int'(bus_a.hcnt), 0);
        check_int("midrst_v", int'(bus_a.vcnt), 0);
        check_int("midrst_syncs", int'({bus_a._hsync, bus_a._vsync, bus_a.hblank, bus_a.vblank}), 15);
        for (int i = 0; i < 5; i++) cyc(1, 1, 0, 0, 0);
        check_int("midrst_resume_h", int'(bus_a.hcnt), 5);

        tag = "frame";
        cyc(0, 0, 0, 1, 0);
        ft_cnt = 0;
        for (int i = 0; i < 2 * 16 * 12; i++) begin
            cyc(1, 0, 0, 1, 0);
            if (bus_b.frame_tick) ft_cnt++;
        end
        check_int("frame_ticks", ft_cnt, 2);

        tag = "sparse";
        ft_cnt = 0;
        for (int i = 0; i < 4 * 2 * 16 * 12; i++) begin
            cyc(1, 0, 0, (i % 4) == 3, 0);
            if (bus_b.frame_tick) ft_cnt++;
        end
        check_int("sparse_ticks", ft_cnt, 2);

        tag = "random";
        for (int i = 0; i < 2000; i++) begin
            cyc($urandom_range(0, 199) != 0, 0, 0,
                $urandom_range(0, 1) == 1, $urandom_range(0, 7) == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
